// File: rtl/aeolus_multicycle_core.sv
// aeolus_multicycle_core: FETCH/EXECUTE multi-cycle Aeolus core, external ROM.
// Define AEOLUS_CORE_HALT_EN to stop in HALT after the PC wraps.
module aeolus_multicycle_core #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [2*DATA_WIDTH-1:0] switches,
  input  logic [3:0]              instr_data,
  output logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic [DATA_WIDTH-1:0]   cpu_out,
  output logic                    carry,
  output logic                    shift_flag,
  output logic                    halted
);

  localparam int W = DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    HALT
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [3:0]            ir, ir_n;
  logic [W-1:0]          a, a_n;
  logic [W-1:0]          b, b_n;
  logic [W-1:0]          s, s_n;
  logic [W-1:0]          acc, acc_n;
  logic [W-1:0]          o, o_n;
  logic                  c, c_n;
  logic                  sf, sf_n;
`ifdef AEOLUS_CORE_HALT_EN
  logic                  wrap, wrap_n;
`endif

  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_cin;
  logic [W:0]   sum;

  // One shared adder serves SNZA, SNZS, ADD and SUB
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    unique case (ir)
      4'd8: begin
        add_x = acc;
        add_y = a;
      end
      4'd9: begin
        add_x = acc;
        add_y = s;
      end
      4'd11: begin
        add_y   = ~b;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x}
             + {1'b0, add_y}
             + {{W{1'b0}}, add_cin};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    a_n     = a;
    b_n     = b;
    s_n     = s;
    acc_n   = acc;
    o_n     = o;
    c_n     = c;
    sf_n    = sf;
`ifdef AEOLUS_CORE_HALT_EN
    wrap_n  = wrap;
`endif
    unique case (state)
      FETCH: begin
        if (run) begin
          ir_n    = instr_data;
          pc_n    = pc + PC_ONE;
`ifdef AEOLUS_CORE_HALT_EN
          wrap_n  = wrap | (&pc);
`endif
          state_n = EXECUTE;
        end
      end
      EXECUTE: begin
        unique case (ir)
          4'd0:  a_n = switches[2*W-1:W];
          4'd1:  b_n = switches[W-1:0];
          4'd2:  o_n = acc;
          4'd3:  s_n = a;
          4'd4:  s_n = b;
          4'd5: begin
            s_n  = {s[W-2:0], 1'b0};
            sf_n = s[W-1];
          end
          4'd6: begin
            s_n  = {1'b0, s[W-1:1]};
            sf_n = s[0];
          end
          4'd7: begin
            acc_n = '0;
            c_n   = 1'b0;
          end
          4'd8, 4'd9: begin
            if (sf) begin
              acc_n = sum[W-1:0];
              c_n   = sum[W];
            end
          end
          4'd10, 4'd11: begin
            acc_n = sum[W-1:0];
            c_n   = sum[W];
          end
          4'd12: acc_n = a & b;
          4'd13: acc_n = a | b;
          4'd14: acc_n = a ^ b;
          4'd15: acc_n = ~a;
          default: ;
        endcase
        state_n = FETCH;
`ifdef AEOLUS_CORE_HALT_EN
        if (wrap) state_n = HALT;
`endif
      end
      HALT: ;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      acc   <= '0;
      o     <= '0;
      c     <= 1'b0;
      sf    <= 1'b0;
`ifdef AEOLUS_CORE_HALT_EN
      wrap  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      a     <= a_n;
      b     <= b_n;
      s     <= s_n;
      acc   <= acc_n;
      o     <= o_n;
      c     <= c_n;
      sf    <= sf_n;
`ifdef AEOLUS_CORE_HALT_EN
      wrap  <= wrap_n;
`endif
    end
  end

  assign instr_addr = pc;
  assign cpu_out    = o;
  assign carry      = c;
  assign shift_flag = sf;
`ifdef AEOLUS_CORE_HALT_EN
  assign halted     = (state == HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_aeolus_multicycle_core.sv
// tb_aeolus_multicycle_core: table vectors, hand sequences and a random
// program run against a plain-arithmetic model of the instruction set.
module tb_aeolus_multicycle_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [3:0] instr_data;
  logic [7:0] instr_addr;
  logic [3:0] cpu_out;
  logic       carry;
  logic       shift_flag;
  logic       halted;
  logic [3:0] rom [0:255];

  logic       reset2 = 1'b0;
  logic       run2 = 1'b0;
  logic [7:0] sw2 = 8'h00;
  logic [3:0] instr_data2;
  logic [1:0] addr2;
  logic [3:0] out2;
  logic       c2;
  logic       sf2;
  logic       h2;
  logic [3:0] rom2 [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instr_data  = rom[instr_addr];
  assign instr_data2 = rom2[addr2];

  aeolus_multicycle_core #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .switches(sw),
    .instr_data(instr_data), .instr_addr(instr_addr),
    .cpu_out(cpu_out), .carry(carry),
    .shift_flag(shift_flag), .halted(halted)
  );

  aeolus_multicycle_core #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .switches(sw2),
    .instr_data(instr_data2), .instr_addr(addr2),
    .cpu_out(out2), .carry(c2),
    .shift_flag(sf2), .halted(h2)
  );

  typedef struct {
    string           name;
    logic [0:8][3:0] prog;
    int              len;
    logic [7:0]      sw;
    logic [3:0]      eo;
    logic            ec;
  } vec_t;

  vec_t tbl [9];

  // model state, plain integers
  int ma, mb, ms, macc, mo, mc, msf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic m_reset();
    ma = 0; mb = 0; ms = 0; macc = 0;
    mo = 0; mc = 0; msf = 0;
  endtask

  task automatic m_exec(input int op, input int swv);
    int t;
    case (op)
      0: ma = swv / 16;
      1: mb = swv % 16;
      2: mo = macc;
      3: ms = ma;
      4: ms = mb;
      5: begin msf = ms / 8; ms = (ms * 2) % 16; end
      6: begin msf = ms % 2; ms = ms / 2; end
      7: begin macc = 0; mc = 0; end
      8: if (msf == 1) begin
           t = macc + ma; macc = t % 16; mc = t / 16;
         end
      9: if (msf == 1) begin
           t = macc + ms; macc = t % 16; mc = t / 16;
         end
      10: begin t = ma + mb; macc = t % 16; mc = t / 16; end
      11: begin t = ma + (15 - mb) + 1; macc = t % 16; mc = t / 16; end
      12: macc = ma & mb;
      13: macc = ma | mb;
      14: macc = ma ^ mb;
      default: macc = 15 - ma;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'h0;
    rom2[0] = 4'd0; rom2[1] = 4'd1; rom2[2] = 4'd10; rom2[3] = 4'd2;

    tbl[0] = '{"add35",  36'h01A200000, 4, 8'h35, 4'h8, 1'b0};
    tbl[1] = '{"add9a",  36'h01A200000, 4, 8'h9A, 4'h3, 1'b1};
    tbl[2] = '{"sub35",  36'h01B200000, 4, 8'h35, 4'hE, 1'b0};
    tbl[3] = '{"sub53",  36'h01B200000, 4, 8'h53, 4'h2, 1'b1};
    tbl[4] = '{"shadd",  36'h014768682, 9, 8'h35, 4'h3, 1'b0};
    tbl[5] = '{"and35",  36'h01C200000, 4, 8'h35, 4'h1, 1'b0};
    tbl[6] = '{"or35",   36'h01D200000, 4, 8'h35, 4'h7, 1'b0};
    tbl[7] = '{"xor35",  36'h01E200000, 4, 8'h35, 4'h6, 1'b0};
    tbl[8] = '{"inv35",  36'h0F2000000, 3, 8'h35, 4'hC, 1'b0};

    // reset state
    do_reset();
    check("rst_addr", instr_addr, 0);
    check("rst_out", cpu_out, 0);
    check("rst_carry", carry, 0);
    check("rst_sf", shift_flag, 0);
    check("rst_halted", halted, 0);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) rom[j] = tbl[i].prog[j];
      do_reset();
      sw = tbl[i].sw;
      run = 1'b1;
      repeat (2 * tbl[i].len) tick();
      check({tbl[i].name, "_out"}, cpu_out, tbl[i].eo);
      check({tbl[i].name, "_carry"}, carry, tbl[i].ec);
      run = 1'b0;
    end

    // shift flag timing in shift-and-add
    for (int j = 0; j < 9; j++) rom[j] = tbl[4].prog[j];
    do_reset();
    sw = 8'h35;
    run = 1'b1;
    repeat (10) tick();
    check("shadd_sf1", shift_flag, 1);
    repeat (4) tick();
    check("shadd_sf0", shift_flag, 0);
    repeat (4) tick();
    check("shadd_res", cpu_out, 3);

    // asynchronous reset mid-EXECUTE
    rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10;
    rom[3] = 4'd2; rom[4] = 4'd10;
    do_reset();
    sw = 8'h9A;
    run = 1'b1;
    repeat (8) tick();
    check("pre_rst_out", cpu_out, 3);
    check("pre_rst_carry", carry, 1);
    tick();
    check("pre_rst_addr", instr_addr, 5);
    reset = 1'b0;
    #1;
    check("async_out", cpu_out, 0);
    check("async_carry", carry, 0);
    check("async_addr", instr_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_addr", instr_addr, 1);

    // stall in FETCH at address 2
    rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd2;
    do_reset();
    sw = 8'h35;
    run = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_addr", instr_addr, 2);
      check("stall_out", cpu_out, 0);
    end
    run = 1'b1;
    tick();
    check("resume_addr", instr_addr, 3);
    repeat (3) tick();
    check("resume_out", cpu_out, 8);

    // run dropped during EXECUTE finishes the instruction, then stalls
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) tick();
    check("exec_drop_addr", instr_addr, 1);
    run = 1'b1;
    repeat (7) tick();
    check("exec_drop_out", cpu_out, 8);
    run = 1'b0;

    // random programs with random stalls
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 16; j++) rom[j] = 4'($urandom_range(0, 15));
      do_reset();
      m_reset();
      sw = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
        int st;
        run = 1'b0;
        st = $urandom_range(0, 2);
        repeat (st) tick();
        if (st > 0) check("rnd_stall_addr", instr_addr, k);
        run = 1'b1;
        tick();
        tick();
        m_exec(int'(rom[k]), int'(sw));
        check("rnd_out", cpu_out, mo);
        check("rnd_carry", carry, mc);
        check("rnd_sf", shift_flag, msf);
        check("rnd_addr", instr_addr, k + 1);
      end
      run = 1'b0;
    end

    // PC wrap on the narrow core
    @(negedge clk);
    reset2 = 1'b1;
    run2 = 1'b1;
    sw2 = 8'h35;
    repeat (8) tick();
    check("wrap_out", out2, 8);
    check("wrap_addr", addr2, 0);
`ifdef AEOLUS_CORE_HALT_EN
    check("wrap_halted", h2, 1);
    sw2 = 8'h9A;
    repeat (4) tick();
    check("halt_out", out2, 8);
    check("halt_addr", addr2, 0);
    check("halt_stays", h2, 1);
`else
    check("wrap_halted", h2, 0);
    sw2 = 8'h9A;
    tick();
    check("rewrap_addr", addr2, 1);
    repeat (7) tick();
    check("rewrap_out", out2, 3);
    check("rewrap_carry", c2, 1);
    check("rewrap_halted", h2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
